fifo_rd_ctrl: RTL and testbench
===============================

Name: fifo_rd_ctrl

Overview:
Read-side controller for the asynchronous FIFO, running entirely in the read clock domain. It compares its read pointer with the write pointer, which arrives already synchronized and Gray-coded. It issues reads to the two-port RAM and tracks the RAM's fixed read latency with a valid-token pipeline. A small prefetch buffer absorbs in-flight words, so the downstream sees a valid/ready stream at full throughput. It returns a Gray read pointer to the write domain.

Parameters:
DEPTH, 16, FIFO/RAM depth in words; power of two.
DATA_WIDTH, 32, word width.
ADDR_WIDTH, 4, log2(DEPTH); pointers are ADDR_WIDTH+1 bits.
OUTPUT_REG, 1, RAM read-pipeline stages (L); must equal the RAM instance's value; 0 allowed.
BUF_DEPTH (localparam), OUTPUT_REG+2, prefetch buffer entries.

Ports:
clk_rd  in  1  read-domain clock
rst_n  in  1  asynchronous active-low reset
wptr_gray_sync  in  ADDR_WIDTH+1  write pointer, Gray, already synchronized to clk_rd
ram_en_rd  out  1  RAM read enable
ram_addr_rd  out  ADDR_WIDTH  RAM read address
ram_data_rd  in  DATA_WIDTH  RAM read data; valid L cycles after issue
m_valid  out  1  output word valid
m_ready  in  1  downstream accepts
m_data  out  DATA_WIDTH  output word
rptr_gray  out  ADDR_WIDTH+1  read pointer, Gray, registered, to the write domain
empty  out  1  RAM holds no unissued words
level  out  ADDR_WIDTH+1  registered count of unissued words in RAM

Behaviour:
- Reset: async, active-low, on all flops. During reset and until the first edge after release: ram_en_rd=0, ram_addr_rd=0, m_valid=0, m_data=0, rptr_gray=0, empty=1, level=0. Token pipeline and buffer are cleared.
- After reset, ram_en_rd=1 constantly. The RAM pipeline advances every cycle, and validity is carried only by the token pipeline.
- Internal state: rbin, the binary read pointer (ADDR_WIDTH+1 bits); wbin = gray2bin(wptr_gray_sync), combinational.
- empty = (rbin == wbin), combinational from the registered rbin and the input. level = wbin - rbin (mod 2^(ADDR_WIDTH+1)), registered.
- Issue condition: issue = !empty && (occ + inflight < BUF_DEPTH). occ and inflight are registered counts. m_ready has no combinational path to ram_addr_rd.
- On issue: ram_addr_rd = rbin[ADDR_WIDTH-1:0]; rbin increments; rptr_gray <= bin2gray(rbin+1). A token enters stage 0.
- The RAM samples its array in the issue cycle, so advancing rptr on issue is safe even though the word is not yet consumed.
- Token pipeline is L stages. For L=0, ram_data_rd is captured in the issue cycle. For L>0, the word returned while the token sits in the last stage is written into the buffer.
- Latency: issue at cycle t gives m_valid at t+L+1 if the buffer was empty.
- Buffer: circular, BUF_DEPTH entries. m_valid = (occ != 0); m_data = head entry. Pop on m_valid && m_ready. A simultaneous push and pop keeps occ unchanged. Overflow is impossible by the credit rule; assert this in simulation.
- Ordering: words are delivered strictly in address order with no loss or duplication.
- Wrap: the address wraps DEPTH-1 -> 0 and the MSB of rbin toggles. Full distance DEPTH gives level=DEPTH.
- m_valid is held, and m_data is stable, while m_ready=0.
- Reset mid-stream: all buffered and in-flight words are discarded; the write side must be reset together.

Decomposition:
- Package fifo_pkg: functions bin2gray and gray2bin; localparam PTR_WIDTH = ADDR_WIDTH+1.
- Sub-module rd_prefetch_buf: single-clock circular buffer holding occ and the head/tail pointers.
- Token pipeline and pointer logic stay in the top level.

Test Plan:
- Reset with wptr_gray_sync=0 -> empty=1, m_valid=0, ram_en_rd=0 during reset, rptr_gray=00000, level=0.
- L=1, RAM preloaded 0xA0/0xA1/0xA2 at 0..2, wptr_gray_sync=gray(3)=00010, m_ready=1 -> ram_addr_rd 0,1,2 on consecutive cycles; m_valid first at issue+2; m_data A0,A1,A2 back-to-back; final rptr_gray=00010, empty=1.
- L=2, 10 words, m_ready=0 -> issue stops at occ+inflight=4; m_data=word0 held stable; release m_ready -> all 10 words delivered in order, no gaps after the first.
- Wrap: deliver 20 words through DEPTH=16 in two batches of 10 -> ram_addr_rd 15 followed by 0; final rptr_gray=gray(20)=11110; data in order.
- Full: wptr_gray_sync=gray(16)=11000 with rbin=0 -> level=16, empty=0; 16 reads drain to empty=1, level=0.
- Reset asserted with 2 words buffered and 1 in flight -> m_valid=0 immediately (async); after release, no stale word appears; rptr_gray=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO: pointer width and Gray/binary conversion.
// The conversions work on a wide word so any pointer width can cast in and out.
package fifo_pkg;
    localparam int ADDR_WIDTH = 4;
    localparam int PTR_WIDTH  = ADDR_WIDTH + 1;
    localparam int MAX_PTR_W  = 32;

    typedef logic [MAX_PTR_W-1:0] ptr_word_t;

    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down, done in log2 steps.
    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b = g;
        for (int s = 1; s < MAX_PTR_W; s = s << 1)
            b = b ^ (b >> s);
        return b;
    endfunction
endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bus of the async FIFO: RAM read port plus the downstream valid/ready stream.
interface fifo_rd_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic                  ram_en_rd;
    logic [ADDR_WIDTH-1:0] ram_addr_rd;
    logic [DATA_WIDTH-1:0] ram_data_rd;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        output ram_en_rd, ram_addr_rd, m_valid, m_data,
        input  ram_data_rd, m_ready
    );

    modport slave (
        input  ram_en_rd, ram_addr_rd, m_valid, m_data,
        output ram_data_rd, m_ready
    );
endinterface

// File: rtl/rd_prefetch_buf.sv
// Small circular buffer that catches words returning from the RAM pipeline
// and presents the head entry as a valid/ready stream.
module rd_prefetch_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int BUF_DEPTH  = 3,
    localparam int CW        = $clog2(BUF_DEPTH + 1),
    localparam int IW        = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [CW-1:0]         occ_o
);
    logic [BUF_DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
    logic [IW-1:0]                        head_q, tail_q;
    logic [CW-1:0]                        occ_q, occ_d;
    logic                                 pop;

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] p);
        return (p == IW'(BUF_DEPTH - 1)) ? '0 : p + IW'(1);
    endfunction

    assign valid_o = (occ_q != '0);
    assign data_o  = mem_q[head_q];
    assign occ_o   = occ_q;
    assign pop     = valid_o && ready_i;
    assign occ_d   = occ_q + CW'(push_i) - CW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[tail_q] <= push_data_i;
                tail_q        <= nxt(tail_q);
            end
            if (pop)
                head_q <= nxt(head_q);
            occ_q <= occ_d;
        end
    end

    // The issue credit rule upstream must keep a push from landing on a full buffer.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !pop && (occ_q == CW'(BUF_DEPTH))));
endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: pointer compare, RAM read issue with a
// latency token pipeline, prefetch buffer, and Gray read pointer back to the writer.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int OUTPUT_REG = 1
) (
    input  logic                  clk_rd,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH:0]   wptr_gray_sync,
    fifo_rd_ctrl_if.master        bus,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   level
);
    localparam int PW        = ADDR_WIDTH + 1;
    localparam int L         = OUTPUT_REG;
    localparam int BUF_DEPTH = OUTPUT_REG + 2;
    localparam int CW        = $clog2(BUF_DEPTH + 1);

    logic [PW-1:0] rbin_q, rbin_d, wbin, rptr_gray_q, level_q;
    logic          ram_en_q;
    logic          issue, push;
    logic [CW-1:0] occ, inflight_q, inflight_d;

    assign wbin   = PW'(gray2bin(ptr_word_t'(wptr_gray_sync)));
    assign empty  = (rbin_q == wbin);
    // Credit: every word issued already owns a buffer slot, so the buffer never overflows.
    assign issue  = !empty &&
                    (((CW+1)'(occ) + (CW+1)'(inflight_q)) < (CW+1)'(BUF_DEPTH));
    assign rbin_d = rbin_q + PW'(issue);

    assign bus.ram_en_rd   = ram_en_q;
    assign bus.ram_addr_rd = rbin_q[ADDR_WIDTH-1:0];
    assign rptr_gray       = rptr_gray_q;
    assign level           = level_q;

    generate
        if (L == 0) begin : g_nolat
            // Combinational RAM read: the word is present in the issue cycle.
            assign push       = issue;
            assign inflight_d = '0;
        end else begin : g_lat
            logic [L-1:0] tok_q;

            assign push       = tok_q[L-1];
            assign inflight_d = inflight_q + CW'(issue) - CW'(push);

            always_ff @(posedge clk_rd or negedge rst_n) begin
                if (!rst_n) tok_q <= '0;
                else        tok_q <= (tok_q << 1) | L'(issue);
            end
        end
    endgenerate

    always_ff @(posedge clk_rd or negedge rst_n) begin
        if (!rst_n) begin
            rbin_q      <= '0;
            rptr_gray_q <= '0;
            level_q     <= '0;
            ram_en_q    <= 1'b0;
            inflight_q  <= '0;
        end else begin
            rbin_q      <= rbin_d;
            rptr_gray_q <= PW'(bin2gray(ptr_word_t'(rbin_d)));
            level_q     <= wbin - rbin_q;
            ram_en_q    <= 1'b1;
            inflight_q  <= inflight_d;
        end
    end

    rd_prefetch_buf #(
        .DATA_WIDTH(DATA_WIDTH),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk        (clk_rd),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_data_i(bus.ram_data_rd),
        .ready_i    (bus.m_ready),
        .valid_o    (bus.m_valid),
        .data_o     (bus.m_data),
        .occ_o      (occ)
    );

    // A well-behaved writer never runs more than DEPTH words ahead.
    assert property (@(posedge clk_rd) disable iff (!rst_n) level_q <= PW'(DEPTH));
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: RAM and writer models, a count/queue-based reference of
// the read side checked every cycle, plus literal pins for the directed scenarios.
module tb_fifo_rd_ctrl;
    localparam int DEPTH = 16;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int L     = 2;
    localparam int BUFD  = L + 2;

    logic          clk_rd = 1'b0;
    logic          rst_n  = 1'b0;
    logic [AW:0]   wptr_gray_sync = '0;
    logic [AW:0]   rptr_gray, level;
    logic          empty;

    fifo_rd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fifo_rd_ctrl #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUTPUT_REG(L)
    ) dut (
        .clk_rd        (clk_rd),
        .rst_n         (rst_n),
        .wptr_gray_sync(wptr_gray_sync),
        .bus           (bus),
        .rptr_gray     (rptr_gray),
        .empty         (empty),
        .level         (level)
    );

    always #5 clk_rd = ~clk_rd;

    // RAM: address sampled when enabled, data appears L cycles later
    logic [DW-1:0] mem   [DEPTH];
    logic [DW-1:0] rpipe [1:L];
    always @(posedge clk_rd) begin
        for (int k = L; k >= 2; k--) rpipe[k] <= rpipe[k-1];
        if (bus.ram_en_rd) rpipe[1] <= mem[bus.ram_addr_rd];
    end
    assign bus.ram_data_rd = rpipe[L];

    function automatic int g5(input int n);
        int m;
        m = n & 31;
        return m ^ (m >> 1);
    endfunction

    // writer-side state (owned by the stimulus process)
    logic [DW-1:0] words [4096];
    int wcount = 0;
    int pin_req = 0, pin_id = 0, lat = 0, tmo = 0;

    // checker-side state (owned by the compare process)
    int vecs = 0, errs = 0;
    int m_iss = 0, m_b = 0, cyc = 0, since_rel = 0, lvl_exp = 0, del_cnt = 0;
    int pin_seen = 0;
    int tokq [$];

    task automatic chk(input string nm, input longint act, input longint exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk_rd) begin : compare
        int  w, infl;
        bit  iss_now, push_now, pop_now;
        if (!rst_n) begin
            chk("rst ram_en", bus.ram_en_rd, 0);
            chk("rst ram_addr", bus.ram_addr_rd, 0);
            chk("rst m_valid", bus.m_valid, 0);
            chk("rst m_data", bus.m_data, 0);
            chk("rst rptr_gray", rptr_gray, 0);
            chk("rst empty", empty, 1);
            chk("rst level", level, 0);
            m_iss = 0; m_b = 0; cyc = 0; since_rel = 0; lvl_exp = 0; del_cnt = 0;
            tokq.delete();
        end else begin
            w = wcount;
            chk("ram_en", bus.ram_en_rd, since_rel > 0);
            chk("ram_addr", bus.ram_addr_rd, m_iss % DEPTH);
            chk("rptr_gray", rptr_gray, g5(m_iss));
            chk("empty", empty, w == m_iss);
            chk("level", level, lvl_exp);
            chk("m_valid", bus.m_valid, m_b != 0);
            if (m_b != 0) chk("m_data", bus.m_data, words[del_cnt]);

            if (pin_req != pin_seen) begin
                pin_seen = pin_req;
                case (pin_id)
                    1: begin chk("pin3 rptr_gray", rptr_gray, 5'b00010);
                             chk("pin3 empty", empty, 1); end
                    2: chk("pin first-valid latency", lat, 3);
                    3: begin chk("pin stall m_valid", bus.m_valid, 1);
                             chk("pin stall m_data", bus.m_data, 32'h000000A3);
                             chk("pin stall rptr_gray", rptr_gray, 5'b00100); end
                    4: begin chk("pin wrap rptr_gray", rptr_gray, 5'b11110);
                             chk("pin wrap empty", empty, 1); end
                    5: begin chk("pin full level", level, 16);
                             chk("pin full empty", empty, 0); end
                    6: begin chk("pin drain level", level, 0);
                             chk("pin drain empty", empty, 1); end
                    7: begin chk("pin post-rst rptr_gray", rptr_gray, 0);
                             chk("pin post-rst m_valid", bus.m_valid, 0); end
                    8: chk("wait timeouts", tmo, 0);
                    default: ;
                endcase
            end

            // what the coming edge does: issue under credit, land after L, pop on handshake
            infl     = tokq.size();
            iss_now  = (w != m_iss) && (m_b + infl < BUFD);
            pop_now  = (m_b != 0) && bus.m_ready;
            lvl_exp  = (w - m_iss) & 31;
            if (iss_now) begin
                m_iss++;
                tokq.push_back(cyc);
            end
            push_now = (tokq.size() > 0) && (tokq[0] == cyc - L);
            if (push_now) void'(tokq.pop_front());
            m_b = m_b + int'(push_now) - int'(pop_now);
            if (m_b > BUFD) chk("model buffer bound", m_b, BUFD);
            if (pop_now) del_cnt++;
            cyc++;
            since_rel++;
        end
    end

    task automatic put(input logic [DW-1:0] d);
        mem[wcount % DEPTH] = d;
        words[wcount]       = d;
        wcount++;
    endtask

    task automatic publish();
        wptr_gray_sync = 5'(g5(wcount));
    endtask

    task automatic cyc1();
        @(posedge clk_rd); #1;
    endtask

    task automatic pin(input int id);
        pin_id = id;
        pin_req++;
        cyc1();
    endtask

    task automatic wait_deliv(input int target);
        int n;
        n = 0;
        while (del_cnt < target && n < 2000) begin cyc1(); n++; end
        if (del_cnt < target) tmo++;
    endtask

    task automatic do_reset();
        #1;
        wcount = 0; wptr_gray_sync = '0; rst_n = 1'b0;
        repeat (2) @(posedge clk_rd);
        #3 rst_n = 1'b1;
        cyc1();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.m_ready = 1'b0;
        repeat (3) @(posedge clk_rd);
        #3 rst_n = 1'b1;
        cyc1();
        cyc1();

        // three words, free-running sink
        bus.m_ready = 1'b1;
        for (int i = 0; i < 3; i++) put(32'hA0 + 32'(i));
        publish();
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_rd);
            if (bus.m_valid) break;
            lat++;
        end
        cyc1();
        pin(2);
        wait_deliv(3);
        cyc1(); cyc1();
        pin(1);

        // stalled sink: issue stops at the credit limit, head held
        bus.m_ready = 1'b0;
        for (int i = 3; i < 13; i++) put(32'hA0 + 32'(i));
        publish();
        repeat (12) cyc1();
        pin(3);
        bus.m_ready = 1'b1;
        wait_deliv(13);

        // carry the address across the wrap
        for (int i = 13; i < 20; i++) put(32'hA0 + 32'(i));
        publish();
        wait_deliv(20);
        repeat (3) cyc1();
        pin(4);

        // full distance from rbin=0
        bus.m_ready = 1'b0;
        do_reset();
        cyc1();
        for (int i = 0; i < 16; i++) put($urandom);
        publish();
        cyc1();
        pin(5);
        bus.m_ready = 1'b1;
        wait_deliv(16);
        repeat (3) cyc1();
        pin(6);

        // reset with words buffered and in flight
        bus.m_ready = 1'b0;
        for (int i = 0; i < 3; i++) put($urandom);
        publish();
        repeat (4) @(posedge clk_rd);
        do_reset();
        bus.m_ready = 1'b1;
        repeat (5) cyc1();
        pin(7);

        // random traffic with varying sink pressure
        for (int i = 0; i < 1500; i++) begin
            int mode, n;
            mode = (i / 100) % 3;
            case (mode)
                0: bus.m_ready = 1'b1;
                1: bus.m_ready = ($urandom_range(0, 1) == 1);
                default: bus.m_ready = ($urandom_range(0, 9) == 0);
            endcase
            if ($urandom_range(0, 2) == 0) begin
                n = $urandom_range(1, 3);
                while (n > 0 && (wcount - del_cnt) < DEPTH) begin
                    put($urandom);
                    n--;
                end
                publish();
            end
            cyc1();
        end
        bus.m_ready = 1'b1;
        wait_deliv(wcount);
        repeat (3) cyc1();
        pin(8);
        @(negedge clk_rd);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
